// File: rtl/branch_pkg.sv
// Shared types and default widths for the branch unit and its condition evaluator.
// Optional link-register support is selected with the BRANCH_LINK_EN macro.
package branch_pkg;

    localparam int PC_W_DEF  = 9;
    localparam int OFF_W_DEF = 8;

    typedef enum logic [2:0] {
        B   = 3'b000,
        BEQ = 3'b001,
        BNE = 3'b010,
        BLT = 3'b011,
        BLE = 3'b100
    } cond_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EVAL   = 2'b01,
        COMMIT = 2'b10
    } state_e;

endpackage

// File: rtl/branch_unit_if.sv
// Branch request handshake between instruction fetch (master) and the branch unit (slave).
// The link request line exists only when BRANCH_LINK_EN is defined.
interface branch_unit_if #(
    parameter int OFF_W = branch_pkg::OFF_W_DEF
);

    logic             br_valid;
    logic             br_ready;
    logic [2:0]       cond;
    logic [OFF_W-1:0] off;
`ifdef BRANCH_LINK_EN
    logic             link;

    modport master (output br_valid, output cond, output off, output link, input br_ready);
    modport slave  (input br_valid, input cond, input off, input link, output br_ready);
`else
    modport master (output br_valid, output cond, output off, input br_ready);
    modport slave  (input br_valid, input cond, input off, output br_ready);
`endif

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator over the {Z,N,V} status flags.
// Reserved condition codes never take the branch.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic       z_i,
    input  logic       n_i,
    input  logic       v_i,
    output logic       take_o
);

    // Decode the condition code against the flags.
    always_comb begin
        take_o = 1'b0;
        case (cond_i)
            B:       take_o = 1'b1;
            BEQ:     take_o = z_i;
            BNE:     take_o = ~z_i;
            BLT:     take_o = n_i ^ v_i;
            BLE:     take_o = (n_i ^ v_i) | z_i;
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: status flag register, program counter and a three-state branch FSM.
// Defining BRANCH_LINK_EN adds a link register updated on taken, linked branches.
module branch_unit
    import branch_pkg::*;
#(
    parameter int              PC_W   = PC_W_DEF,
    parameter int              OFF_W  = OFF_W_DEF,
    parameter logic [PC_W-1:0] PC_RST = {PC_W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_s,
    input  logic             Z_in,
    input  logic             N_in,
    input  logic             V_in,
    input  logic             pc_inc,
    branch_unit_if.slave     br,
    output logic [PC_W-1:0]  pc_out,
    output logic [2:0]       status_out,
    output logic             done,
    output logic             taken
`ifdef BRANCH_LINK_EN
    ,output logic [PC_W-1:0] lr_out
`endif
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [2:0]       status_q, status_d;
    logic [2:0]       cond_q, cond_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic             taken_q, taken_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
`ifdef BRANCH_LINK_EN
    logic             link_q, link_d;
    logic [PC_W-1:0]  lr_q, lr_d;
`endif

    logic             take_s;
    logic             accept_s;
    logic [PC_W-1:0]  pc_plus1_s;
    logic [PC_W-1:0]  off_sext_s;

    assign accept_s   = br.br_valid & ready_q;
    assign pc_plus1_s = pc_q + PC_ONE;
    assign off_sext_s = {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};

    // Decision uses the status register as it stands during EVAL.
    branch_cond_eval u_cond_eval (
        .cond_i (cond_q),
        .z_i    (status_q[2]),
        .n_i    (status_q[1]),
        .v_i    (status_q[0]),
        .take_o (take_s)
    );

    // Next-state, PC, status and handshake logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        status_d = status_q;
        cond_d   = cond_q;
        off_d    = off_q;
        target_d = target_q;
        taken_d  = 1'b0;
        done_d   = 1'b0;
        ready_d  = 1'b0;
`ifdef BRANCH_LINK_EN
        link_d   = link_q;
        lr_d     = lr_q;
`endif

        if (load_s) begin
            status_d = {Z_in, N_in, V_in};
        end else begin
            status_d = status_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    cond_d  = br.cond;
                    off_d   = br.off;
`ifdef BRANCH_LINK_EN
                    link_d  = br.link;
`endif
                    state_d = EVAL;
                    ready_d = 1'b0;
                end else if (pc_inc) begin
                    pc_d    = pc_plus1_s;
                    ready_d = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            EVAL: begin
                taken_d  = take_s;
                target_d = take_s ? (pc_plus1_s + off_sext_s) : pc_plus1_s;
                done_d   = 1'b1;
                state_d  = COMMIT;
            end
            COMMIT: begin
                pc_d    = target_q;
                state_d = IDLE;
                ready_d = 1'b1;
`ifdef BRANCH_LINK_EN
                if (taken_q && link_q) begin
                    lr_d = pc_plus1_s;
                end else begin
                    lr_d = lr_q;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= PC_RST;
            status_q <= 3'b000;
            cond_q   <= 3'b000;
            off_q    <= {OFF_W{1'b0}};
            target_q <= {PC_W{1'b0}};
            taken_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef BRANCH_LINK_EN
            link_q   <= 1'b0;
            lr_q     <= {PC_W{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            status_q <= status_d;
            cond_q   <= cond_d;
            off_q    <= off_d;
            target_q <= target_d;
            taken_q  <= taken_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
`ifdef BRANCH_LINK_EN
            link_q   <= link_d;
            lr_q     <= lr_d;
`endif
        end
    end

    assign br.br_ready = ready_q;
    assign pc_out      = pc_q;
    assign status_out  = status_q;
    assign done        = done_q;
    assign taken       = taken_q;
`ifdef BRANCH_LINK_EN
    assign lr_out      = lr_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: cycle-level reference model plus literal spot checks.
// Covers the link register as well when BRANCH_LINK_EN is defined.
module tb_branch_unit;

    localparam int PC_W  = 9;
    localparam int OFF_W = 8;
    localparam int PC_MOD = 512;

    logic             clk = 1'b0;
    logic             reset_n, load_s, Z_in, N_in, V_in, pc_inc;
    logic [PC_W-1:0]  pc_out;
    logic [2:0]       status_out;
    logic             done, taken;
`ifdef BRANCH_LINK_EN
    logic [PC_W-1:0]  lr_out;
`endif

    always #5 clk = ~clk;

    branch_unit_if #(.OFF_W(OFF_W)) bif ();

    branch_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .PC_RST(9'd0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_s     (load_s),
        .Z_in       (Z_in),
        .N_in       (N_in),
        .V_in       (V_in),
        .pc_inc     (pc_inc),
        .br         (bif),
        .pc_out     (pc_out),
        .status_out (status_out),
        .done       (done),
        .taken      (taken)
`ifdef BRANCH_LINK_EN
        ,.lr_out    (lr_out)
`endif
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decision straight from the condition table.
    function automatic bit decide(input logic [2:0] c, input logic [2:0] s);
        bit z, n, v;
        z = s[2]; n = s[1]; v = s[0];
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n != v;
            3'd4:    return (n != v) || z;
            default: return 1'b0;
        endcase
    endfunction

    // Model: decision is resolved eagerly at accept, then released after the fixed latency.
    int       m_pc = 0, m_tgt = 0, m_lr = 0, m_wait = 0;
    logic [2:0] m_st = 3'b000;
    bit       m_tk = 1'b0;

    always @(posedge clk) begin : model
        logic [2:0] st;
        int t;
        bit d;
        if (!reset_n) begin
            m_pc <= 0; m_st <= 3'b000; m_wait <= 0; m_tk <= 1'b0; m_lr <= 0;
        end else begin
            st = load_s ? {Z_in, N_in, V_in} : m_st;
            m_st <= st;
            if (m_wait == 0) begin
                if (bif.br_valid) begin
                    d = decide(bif.cond, st);
                    t = m_pc + 1 + (d ? int'($signed(bif.off)) : 0);
                    m_tgt  <= ((t % PC_MOD) + PC_MOD) % PC_MOD;
                    m_tk   <= d;
                    m_wait <= 2;
                end else if (pc_inc) begin
                    m_pc <= (m_pc + 1) % PC_MOD;
                end
            end else if (m_wait == 2) begin
                m_wait <= 1;
            end else begin
                m_pc   <= m_tgt;
                m_wait <= 0;
                if (m_tk) m_lr <= (m_pc + 1) % PC_MOD;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",  bif.br_ready, m_wait == 0);
            check("done",   done,         m_wait == 1);
            check("taken",  taken,        (m_wait == 1) && m_tk);
            check("pc",     pc_out,       m_pc);
            check("status", status_out,   m_st);
`ifdef BRANCH_LINK_EN
            check("lr",     lr_out,       m_lr);
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_flags(input logic z, input logic n, input logic v);
        load_s = 1'b1; Z_in = z; N_in = n; V_in = v;
        cyc();
        load_s = 1'b0;
    endtask

    // Issue one branch; returns at the negedge of the COMMIT cycle.
    task automatic do_branch(input logic [2:0] c, input logic [7:0] o);
        bif.br_valid = 1'b1; bif.cond = c; bif.off = o;
        cyc();
        bif.br_valid = 1'b0; bif.cond = ~c; bif.off = ~o;
        cyc();
    endtask

    initial begin
        reset_n = 1'b0; load_s = 1'b0; Z_in = 1'b0; N_in = 1'b0; V_in = 1'b0; pc_inc = 1'b0;
        bif.br_valid = 1'b0; bif.cond = 3'd0; bif.off = 8'd0;
`ifdef BRANCH_LINK_EN
        bif.link = 1'b1;
`endif
        repeat (2) cyc();
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Arbitrary activity, then reset in the middle of a branch.
        pc_inc = 1'b1; load_s = 1'b1; Z_in = 1'b1; N_in = 1'b1;
        repeat (2) cyc();
        pc_inc = 1'b0; load_s = 1'b0; Z_in = 1'b0; N_in = 1'b0;
        bif.br_valid = 1'b1; bif.cond = 3'd0; bif.off = 8'd7;
        cyc();
        bif.br_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) cyc();
        check("rst_pc", pc_out, 32'd0);
        check("rst_status", status_out, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_taken", taken, 32'd0);
        reset_n = 1'b1;
        cyc();
        check("rst_ready", bif.br_ready, 32'd1);

        // Increment
        pc_inc = 1'b1;
        repeat (3) cyc();
        pc_inc = 1'b0;
        check("inc3_pc", pc_out, 32'd3);

        // BEQ taken at pc=3, off=5
        set_flags(1'b1, 1'b0, 1'b0);
        do_branch(3'b001, 8'h05);
        check("beq_done", done, 32'd1);
        check("beq_taken", taken, 32'd1);
        cyc();
        check("beq_pc", pc_out, 32'd9);
        check("beq_done_low", done, 32'd0);

        // BLT not taken with N=V
        set_flags(1'b0, 1'b1, 1'b1);
        do_branch(3'b011, 8'h10);
        check("blt_taken", taken, 32'd0);
        cyc();
        check("blt_pc", pc_out, 32'd10);

        // BLE taken with N^V
        set_flags(1'b0, 1'b1, 1'b0);
        do_branch(3'b100, 8'h02);
        check("ble_taken", taken, 32'd1);
        cyc();
        check("ble_pc", pc_out, 32'd13);

        // BNE negative offset wrapping below zero
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        do_branch(3'b010, 8'hFE);
        check("bne_taken", taken, 32'd1);
        cyc();
        check("bne_wrap_pc", pc_out, 32'd511);
        pc_inc = 1'b1;
        cyc();
        pc_inc = 1'b0;
        check("inc_wrap_pc", pc_out, 32'd0);

        // Flag load in the accept cycle is seen by the decision
        load_s = 1'b1; Z_in = 1'b1; N_in = 1'b0; V_in = 1'b0;
        bif.br_valid = 1'b1; bif.cond = 3'b001; bif.off = 8'h03;
        cyc();
        load_s = 1'b0; bif.br_valid = 1'b0;
        cyc();
        check("ord_beq_taken", taken, 32'd1);
        cyc();
        check("ord_beq_pc", pc_out, 32'd4);

        // Flag load during EVAL does not affect the current branch
        bif.br_valid = 1'b1; bif.cond = 3'b010; bif.off = 8'h02;
        cyc();
        bif.br_valid = 1'b0;
        load_s = 1'b1; Z_in = 1'b0; N_in = 1'b0; V_in = 1'b0;
        cyc();
        load_s = 1'b0;
        check("ord_bne_done", done, 32'd1);
        check("ord_bne_taken", taken, 32'd0);
        check("ord_bne_status", status_out, 32'd0);
        cyc();
        check("ord_bne_pc", pc_out, 32'd5);

        // Reserved code, then unconditional with large negative offset
        do_branch(3'b110, 8'h20);
        check("rsv_taken", taken, 32'd0);
        cyc();
        check("rsv_pc", pc_out, 32'd6);
        do_branch(3'b000, 8'h80);
        check("b_taken", taken, 32'd1);
        cyc();
        check("b_pc", pc_out, 32'd391);

        // Reset during EVAL suppresses the done pulse
        bif.br_valid = 1'b1; bif.cond = 3'b000; bif.off = 8'h04;
        cyc();
        bif.br_valid = 1'b0;
        reset_n = 1'b0;
        cyc();
        check("midrst_done", done, 32'd0);
        check("midrst_pc", pc_out, 32'd0);
        reset_n = 1'b1;
        cyc();
        check("midrst_done2", done, 32'd0);

        // Back-pressure: valid held across a whole branch
        bif.br_valid = 1'b1; bif.cond = 3'b000; bif.off = 8'h01;
        cyc();
        check("bp_ready_eval", bif.br_ready, 32'd0);
        cyc();
        check("bp_ready_commit", bif.br_ready, 32'd0);
        check("bp_done", done, 32'd1);
        cyc();
        check("bp_ready_idle", bif.br_ready, 32'd1);
        check("bp_pc1", pc_out, 32'd2);
        repeat (3) cyc();
        bif.br_valid = 1'b0;
        check("bp_pc2", pc_out, 32'd4);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Consumer side of the ALU status interface. Latches the ALU Z/N/V flags into a status register and evaluates conditional-branch requests against it.
- Owns the program counter: sequential increment, or relative branch target.
- Sits between the ALU flag outputs and instruction fetch. Three-state FSM with a valid/ready request handshake and a one-cycle done pulse.

Parameters:
- PC_W, 9, program counter width in bits; all PC arithmetic is modulo 2^PC_W.
- OFF_W, 8, branch offset width; sign-extended to PC_W.
- PC_RST, 0, PC value loaded at reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- load_s  in  1  when 1, capture Z_in/N_in/V_in into the status register at this edge.
- Z_in  in  1  ALU zero flag.
- N_in  in  1  ALU negative flag.
- V_in  in  1  ALU overflow flag.
- pc_inc  in  1  request PC+1; honoured only in IDLE with no branch accepted.
- br_valid  in  1  branch request valid.
- br_ready  out  1  1 only in IDLE; a request is accepted when br_valid & br_ready.
- cond  in  3  condition code, sampled at accept.
- off  in  OFF_W  signed offset, sampled at accept.
- pc_out  out  PC_W  current PC register.
- status_out  out  3  status register {Z,N,V}.
- done  out  1  one-cycle pulse in COMMIT.
- taken  out  1  branch decision; valid while done=1, 0 otherwise.

Behaviour:
- Reset (reset_n=0 at an edge), from any state:
  - pc_out=PC_RST, status_out=000, state=IDLE.
  - done=0, taken=0, br_ready=1 once out of reset.
  - Latched cond/off are cleared.
- States are IDLE, EVAL, COMMIT.
- IDLE:
  - br_ready=1.
  - On accept: latch cond and off, go to EVAL; pc_inc is ignored that cycle.
  - Otherwise, if pc_inc=1: pc <= pc+1, with wrap at 2^PC_W-1 -> 0.
- EVAL:
  - br_ready=0.
  - Compute the decision from the current status register, combinationally, through the condition evaluator.
  - Register target = pc+1+sext(off) mod 2^PC_W when taken, else pc+1.
  - Register the decision. Go to COMMIT.
- COMMIT:
  - br_ready=0, done=1, taken=registered decision.
  - pc <= registered target. Go to IDLE.
- Latency: accept edge -> done high 2 cycles later; PC updated at the edge ending COMMIT.
- Throughput: one branch per 3 cycles.
- Condition codes (evaluated on {Z,N,V}):
  - 000 B: always taken.
  - 001 BEQ: Z.
  - 010 BNE: ~Z.
  - 011 BLT: N^V.
  - 100 BLE: (N^V)|Z.
  - 101-111: reserved, never taken (pc+1).
- Status register:
  - load_s is honoured in every state.
  - load_s in the accept cycle is visible to the EVAL decision.
  - load_s during EVAL updates status only after the decision is captured; it does not affect that branch.
- pc_inc is ignored in EVAL and COMMIT; it is not queued.
- br_valid may drop after accept without effect. cond/off changes after accept are ignored.

Optional Feature:
- Macro: BRANCH_LINK_EN.
- Defined:
  - Adds input link (1, sampled at accept) and output lr_out (PC_W, reset 0).
  - On a taken branch with link=1, lr_out <= pc+1 at the COMMIT edge.
  - Not-taken or link=0 leaves lr_out unchanged.
- Undefined: the link and lr_out ports and the register are absent. Branch behaviour is otherwise identical.

Decomposition:
- Package branch_pkg holds:
  - cond_e enum: B, BEQ, BNE, BLT, BLE; encodings as above.
  - state_e enum: IDLE, EVAL, COMMIT.
  - Default PC_W/OFF_W localparams.
- Sub-module branch_cond_eval: purely combinational (cond, Z, N, V) -> take.
- Top holds the FSM, status register, PC and target arithmetic.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles after arbitrary activity -> pc_out=0, status_out=000, done=0, taken=0; br_ready=1 after release.
- Increment: pc_inc=1 for 3 cycles from reset -> pc_out=3. Next, pc_inc with pc=511 -> pc_out=0.
- Taken branch: load_s with Z=1,N=0,V=0; BEQ off=0x05 accepted at pc=3 -> done=1,taken=1 two cycles later; pc_out=9 the cycle after.
- Not taken / negative wrap:
  - BLT with N=1,V=1 at pc=9 -> taken=0, pc_out=10.
  - BNE off=0xFE with Z=0 at pc=0 -> pc_out=511.
- Ordering: load_s Z=1 in the accept cycle of BEQ -> taken=1. BNE with load_s Z=0 asserted in EVAL (prior Z=1) -> taken=0, status_out=000 afterwards. Also check cond=110 -> taken=0.
- Mid-op reset and back-pressure: reset_n=0 during EVAL -> no done pulse, pc_out=0. br_valid held in EVAL/COMMIT -> br_ready=0, second request accepted only on return to IDLE.
